// File: rtl/dmem_resp_pkg.sv
// Shared encodings for the data-memory responder: access widths as produced by
// the decoder's load/store width field, FSM states and the data width.
package dmem_resp_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    SL_W = 2'b00,
    SL_H = 2'b01,
    SL_B = 2'b10,
    SL_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering for the responder: store merge into an existing word and
// load extraction with sign/zero extension. Purely combinational.
module dmem_lane
  import dmem_resp_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] wdata,
  input  size_e             size,
  input  logic [1:0]        byte_off,
  input  logic              zext,
  output logic [DATA_W-1:0] new_word,
  output logic [DATA_W-1:0] load_data
);

  logic [7:0]  lbyte;
  logic [15:0] lhalf;

  always_comb begin
    new_word = word;
    case (size)
      SL_B:    new_word[{byte_off, 3'b000} +: 8]     = wdata[7:0];
      SL_H:    new_word[{byte_off[1], 4'b0000} +: 16] = wdata[15:0];
      SL_W:    new_word = wdata;
      default: new_word = word;
    endcase
  end

  always_comb begin
    lbyte     = word[{byte_off, 3'b000} +: 8];
    lhalf     = word[{byte_off[1], 4'b0000} +: 16];
    load_data = '0;
    case (size)
      SL_B:    load_data = {{24{~zext & lbyte[7]}}, lbyte};
      SL_H:    load_data = {{16{~zext & lhalf[15]}}, lhalf};
      SL_W:    load_data = word;
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: one request at a time, fixed access latency, byte-lane
// store merge / load extract against a word-organised RAM, valid/ready response.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LAT         = 2
)
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e            state, state_nxt;
  logic [3:0]        cnt;

  logic              h_we;
  size_e             h_size;
  logic              h_uns;
  logic [31:0]       h_addr;
  logic [DATA_W-1:0] h_wdata;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] new_word;
  logic [DATA_W-1:0] load_data;
  logic              err;
  logic              exec;

  assign idx = h_addr[IDX_W+1:2];

  // Word index is checked on the full address, so idx is exact whenever err=0.
  always_comb begin
    err = 1'b0;
    if (h_size == SL_X)                                err = 1'b1;
    if (h_size == SL_H && h_addr[0])                   err = 1'b1;
    if (h_size == SL_W && (h_addr[1:0] != 2'b00))      err = 1'b1;
    if ({2'b00, h_addr[31:2]} >= 32'(DEPTH_WORDS))     err = 1'b1;
  end

  always_comb begin
    rd_word = mem[idx];
    exec    = (state == BUSY) && (cnt == '0);
  end

  dmem_lane u_lane (
    .word      (rd_word),
    .wdata     (h_wdata),
    .size      (h_size),
    .byte_off  (h_addr[1:0]),
    .zext      (h_uns),
    .new_word  (new_word),
    .load_data (load_data)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = BUSY;
      end
      BUSY:    if (cnt == '0) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt        <= '0;
      h_we       <= 1'b0;
      h_size     <= SL_W;
      h_uns      <= 1'b0;
      h_addr     <= '0;
      h_wdata    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            h_we    <= req_we;
            h_size  <= size_e'(req_size);
            h_uns   <= req_unsigned;
            h_addr  <= req_addr;
            h_wdata <= req_wdata;
            cnt     <= 4'(LAT - 1);
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            resp_valid <= 1'b1;
            resp_err   <= err;
            resp_rdata <= (err || h_we) ? '0 : load_data;
          end
        end
        RESP: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // RAM is not reset; an asserted rstn forces IDLE, which blocks the commit.
  always_ff @(posedge clk) begin
    if (exec && h_we && !err) mem[idx] <= new_word;
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: directed load/store/extension/error cases plus random
// traffic, checked against a byte-addressed reference memory.
module tb_dmem_resp;
  import dmem_resp_pkg::*;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [7:0] mb [DEPTH*4];

  always #5 clk = ~clk;

  dmem_resp #(.DEPTH_WORDS(DEPTH), .LAT(LAT)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned m_len(input logic [1:0] sz);
    if (sz == 2'b00) return 4;
    if (sz == 2'b01) return 2;
    return 1;
  endfunction

  function automatic bit m_err(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b11) return 1'b1;
    if (a % m_len(sz) != 0) return 1'b1;
    if (a / 4 >= DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_access(input bit we, input logic [1:0] sz, input bit uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output bit e);
    int unsigned n;
    logic [31:0] val;
    e  = m_err(sz, a);
    rd = '0;
    if (e) return;
    n = m_len(sz);
    if (we) begin
      for (int unsigned i = 0; i < n; i++) mb[a + i] = 8'(wd >> (8 * i));
    end else begin
      val = '0;
      for (int unsigned i = 0; i < n; i++) val = val | (32'(mb[a + i]) << (8 * i));
      if (n < 4 && !uns && ((val >> (8 * n - 1)) & 32'd1) == 32'd1)
        val = val | ~((32'd1 << (8 * n)) - 32'd1);
      rd = val;
    end
  endtask

  task automatic do_req(input bit we, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd, input int unsigned bp,
                        output logic [31:0] rd, output bit e);
    logic [31:0] xrd;
    bit          xe;
    int unsigned k;
    m_access(we, sz, uns, a, wd, xrd, xe);
    rd = '0;
    e  = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    if (!req_ready) begin
      chk("req_ready_wait", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    chk("busy_ready", 32'(req_ready), 32'd0);
    chk("busy_valid", 32'(resp_valid), 32'd0);
    req_valid    = 1'($urandom_range(1, 0));
    req_we       = 1'($urandom_range(1, 0));
    req_size     = 2'($urandom_range(3, 0));
    req_unsigned = 1'($urandom_range(1, 0));
    req_addr     = $urandom;
    req_wdata    = $urandom;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!resp_valid && k < 20);
    chk("latency", k, LAT);
    if (!resp_valid) begin req_valid = 1'b0; return; end
    rd = resp_rdata;
    e  = resp_err;
    chk("rdata", rd, xrd);
    chk("err", 32'(e), 32'(xe));
    req_valid = 1'b1;
    for (int unsigned i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_rdata", resp_rdata, xrd);
      chk("bp_err", 32'(resp_err), 32'(xe));
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("hs_valid", 32'(resp_valid), 32'd0);
    chk("hs_ready", 32'(req_ready), 32'd1);
    resp_ready = 1'b0;
  endtask

  initial begin : main
    logic [31:0] rd;
    bit          e;
    logic [31:0] base;
    logic [31:0] a;
    logic [1:0]  sz;
    logic [31:0] wd;

    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    do_req(1, SL_W, 0, 32'h10, 32'hDEADBEEF, 0, rd, e);
    do_req(0, SL_W, 0, 32'h10, 32'h0, 0, rd, e);
    chk("lw_10", rd, 32'hDEADBEEF);
    do_req(1, SL_B, 0, 32'h13, 32'h0000_0080, 1, rd, e);
    do_req(0, SL_B, 0, 32'h13, 32'h0, 0, rd, e);
    chk("lb_13", rd, 32'hFFFFFF80);
    do_req(0, SL_B, 1, 32'h13, 32'h0, 0, rd, e);
    chk("lbu_13", rd, 32'h00000080);
    do_req(0, SL_W, 0, 32'h10, 32'h0, 0, rd, e);
    chk("lw_10_merge", rd, 32'h80ADBEEF);
    do_req(1, SL_H, 0, 32'h22, 32'hAAAA1234, 0, rd, e);
    do_req(0, SL_H, 0, 32'h22, 32'h0, 0, rd, e);
    chk("lh_22", rd, 32'h00001234);
    do_req(1, SL_H, 0, 32'h20, 32'h5555F00D, 0, rd, e);
    do_req(0, SL_H, 1, 32'h20, 32'h0, 0, rd, e);
    chk("lhu_20", rd, 32'h0000F00D);
    do_req(0, SL_H, 0, 32'h20, 32'h0, 0, rd, e);
    chk("lh_20", rd, 32'hFFFFF00D);

    do_req(0, SL_W, 0, 32'h11, 32'h0, 0, rd, e);
    chk("lw_11_err", 32'(e), 32'd1);
    do_req(1, SL_H, 0, 32'h21, 32'hFFFFFFFF, 0, rd, e);
    chk("sh_21_err", 32'(e), 32'd1);
    do_req(1, SL_W, 0, 32'(DEPTH * 4), 32'hFFFFFFFF, 0, rd, e);
    chk("sw_oor_err", 32'(e), 32'd1);
    do_req(1, 2'b11, 0, 32'h20, 32'hFFFFFFFF, 0, rd, e);
    chk("size11_err", 32'(e), 32'd1);
    do_req(0, SL_W, 0, 32'h20, 32'h0, 0, rd, e);
    chk("lw_20_unchanged", rd, 32'h1234F00D);

    do_req(1, SL_W, 0, 32'(DEPTH * 4 - 4), 32'hA5A55A5A, 5, rd, e);
    do_req(0, SL_W, 0, 32'(DEPTH * 4 - 4), 32'h0, 5, rd, e);
    chk("lw_last", rd, 32'hA5A55A5A);

    // Reset during BUSY must drop the pending store.
    do_req(1, SL_W, 0, 32'h40, 32'hCAFEF00D, 0, rd, e);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = SL_W; req_unsigned = 1'b0;
    req_addr = 32'h40; req_wdata = 32'h11111111;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_resp_rdata", resp_rdata, 32'd0);
    chk("mid_rst_resp_err", 32'(resp_err), 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    do_req(0, SL_W, 0, 32'h40, 32'h0, 0, rd, e);
    chk("lw_40_after_rst", rd, 32'hCAFEF00D);

    base = 32'h200;
    for (int unsigned i = 0; i < 16; i++)
      do_req(1, SL_W, 0, base + 4 * i, $urandom, 0, rd, e);
    for (int unsigned i = 0; i < 80; i++) begin
      if ($urandom_range(7, 0) == 0) a = 32'(DEPTH * 4) + $urandom_range(63, 0);
      else                           a = base + $urandom_range(63, 0);
      sz = 2'($urandom_range(3, 0));
      wd = $urandom;
      do_req(1'($urandom_range(1, 0)), sz, 1'($urandom_range(1, 0)), a, wd,
             $urandom_range(2, 0), rd, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
